// File: rtl/jtag_def.sv
// jtag_def: DMI op/status encodings, FSM state encoding and default field widths shared with the DTM.
package jtag_def;
   localparam int DEF_ADDR_BITS      = 6;
   localparam int DEF_DATA_BITS      = 32;
   localparam int DEF_OP_BITS        = 2;
   localparam int DEF_ACCESS_TIMEOUT = 256;
   localparam logic [1:0] DMI_OP_NOP     = 2'b00;
   localparam logic [1:0] DMI_OP_READ    = 2'b01;
   localparam logic [1:0] DMI_OP_WRITE   = 2'b10;
   localparam logic [1:0] DMI_OP_RSVD    = 2'b11;
   localparam logic [1:0] DMI_ST_SUCCESS = 2'b00;
   localparam logic [1:0] DMI_ST_FAILED  = 2'b10;
   typedef enum logic [2:0] {ST_IDLE, ST_ACCESS, ST_RESP, ST_RESP_WAIT, ST_DRAIN} dmi_state_e;
endpackage

// File: rtl/dmi_sync2.sv
// dmi_sync2: two-flop level synchroniser into the core clock domain, resets to 0.
module dmi_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic m;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {q, m} <= 2'b00;
      else        {q, m} <= {m, d};
endmodule

// File: rtl/jtag_dmi_target.sv
// jtag_dmi_target: DM-side DMI endpoint; four-phase request/response handshakes with the DTM
// and a single register-port access per request, with timeout.
module jtag_dmi_target
   import jtag_def::*;
#(
   parameter int DMI_ADDR_BITS  = DEF_ADDR_BITS,
   parameter int DMI_DATA_BITS  = DEF_DATA_BITS,
   parameter int DMI_OP_BITS    = DEF_OP_BITS,
   parameter int ACCESS_TIMEOUT = DEF_ACCESS_TIMEOUT,
   localparam int REQ_BITS      = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS,
   localparam int RESP_BITS     = REQ_BITS
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     dtm_req_valid_i,
   input  logic [REQ_BITS-1:0]      dtm_req_data_i,
   output logic                     dm_ack_o,
   output logic                     dm_resp_o,
   output logic [RESP_BITS-1:0]     dm_resp_data_o,
   input  logic                     dtm_ack_i,
   output logic                     reg_req_o,
   output logic                     reg_we_o,
   output logic [DMI_ADDR_BITS-1:0] reg_addr_o,
   output logic [DMI_DATA_BITS-1:0] reg_wdata_o,
   input  logic                     reg_ready_i,
   input  logic [DMI_DATA_BITS-1:0] reg_rdata_i
);
   localparam int CW = $clog2(ACCESS_TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(ACCESS_TIMEOUT - 1);
   localparam logic [DMI_OP_BITS-1:0] OP_NOP = DMI_OP_BITS'(DMI_OP_NOP);
   localparam logic [DMI_OP_BITS-1:0] OP_READ = DMI_OP_BITS'(DMI_OP_READ);
   localparam logic [DMI_OP_BITS-1:0] OP_WRITE = DMI_OP_BITS'(DMI_OP_WRITE);
   localparam logic [DMI_OP_BITS-1:0] OP_OK = DMI_OP_BITS'(DMI_ST_SUCCESS);
   localparam logic [DMI_OP_BITS-1:0] OP_FAIL = DMI_OP_BITS'(DMI_ST_FAILED);
   localparam logic [DMI_DATA_BITS-1:0] ZERO = '0;
   dmi_state_e state, state_d;
   logic req_s, ack_s, ack_q, ack_d, resp_d, resp_q, reg_req_q, reg_req_d;
   logic [REQ_BITS-1:0] req_q, req_d;
   logic [RESP_BITS-1:0] resp_data_q, resp_data_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [DMI_ADDR_BITS-1:0] in_addr;
   logic [DMI_OP_BITS-1:0] in_op, q_op;
   dmi_sync2 u_sync_req (.clk(clk), .rst_n(rst_n), .d(dtm_req_valid_i), .q(req_s));
   dmi_sync2 u_sync_ack (.clk(clk), .rst_n(rst_n), .d(dtm_ack_i), .q(ack_s));
   assign in_addr        = dtm_req_data_i[REQ_BITS-1 -: DMI_ADDR_BITS];
   assign in_op          = dtm_req_data_i[DMI_OP_BITS-1:0];
   assign q_op           = req_q[DMI_OP_BITS-1:0];
   assign reg_we_o       = q_op == OP_WRITE;
   assign reg_addr_o     = req_q[REQ_BITS-1 -: DMI_ADDR_BITS];
   assign reg_wdata_o    = req_q[DMI_OP_BITS +: DMI_DATA_BITS];
   assign reg_req_o      = reg_req_q;
   assign dm_ack_o       = ack_q;
   assign dm_resp_o      = resp_q;
   assign dm_resp_data_o = resp_data_q;
   // reg_req_o is registered, so it rises the cycle after ACCESS entry and the
   // counter only advances while the request is actually presented.
   always_comb begin
      state_d     = state;
      ack_d       = req_s ? ack_q : 1'b0;
      req_d       = req_q;
      cnt_d       = cnt;
      reg_req_d   = 1'b0;
      resp_data_d = resp_data_q;
      case (state)
         ST_IDLE: if (req_s) begin
            ack_d = 1'b1;
            req_d = dtm_req_data_i;
            cnt_d = '0;
            if (in_op == OP_READ || in_op == OP_WRITE) state_d = ST_ACCESS;
            else begin
               state_d     = ST_RESP;
               resp_data_d = {in_addr, ZERO, in_op == OP_NOP ? OP_OK : OP_FAIL};
            end
         end
         ST_ACCESS: begin
            if (reg_req_q && reg_ready_i) begin
               state_d     = ST_RESP;
               resp_data_d = {reg_addr_o, reg_we_o ? ZERO : reg_rdata_i, OP_OK};
            end else if (reg_req_q && cnt == LAST) begin
               state_d     = ST_RESP;
               resp_data_d = {reg_addr_o, ZERO, OP_FAIL};
            end else begin
               reg_req_d = 1'b1;
               cnt_d     = reg_req_q ? cnt + CW'(1) : cnt;
            end
         end
         ST_RESP:      state_d = ack_s ? ST_RESP_WAIT : ST_RESP;
         ST_RESP_WAIT: state_d = ack_s ? ST_RESP_WAIT : ST_DRAIN;
         ST_DRAIN:     state_d = req_s ? ST_DRAIN : ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
      resp_d = state_d == ST_RESP;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= ST_IDLE;
         ack_q       <= 1'b0;
         resp_q      <= 1'b0;
         reg_req_q   <= 1'b0;
         req_q       <= '0;
         resp_data_q <= '0;
         cnt         <= '0;
      end else begin
         state       <= state_d;
         ack_q       <= ack_d;
         resp_q      <= resp_d;
         reg_req_q   <= reg_req_d;
         req_q       <= req_d;
         resp_data_q <= resp_data_d;
         cnt         <= cnt_d;
      end
endmodule

// File: tb/tb_jtag_dmi_target.sv
// tb_jtag_dmi_target: directed DTM/register-port transactions against jtag_dmi_target.
module tb_jtag_dmi_target;
   logic clk = 0, rst_n = 0;
   logic dtm_req_valid_i = 0, dtm_ack_i = 0, reg_ready_i = 0;
   logic [39:0] dtm_req_data_i = '0;
   logic dm_ack_o, dm_resp_o, reg_req_o, reg_we_o;
   logic [39:0] dm_resp_data_o;
   logic [5:0] reg_addr_o;
   logic [31:0] reg_wdata_o, reg_rdata_i = '0;
   int checks = 0, failures = 0;
   int req_cycles = 0, resp_count = 0, ready_lat = 0;
   logic last_we = 0, prev_resp = 0;
   logic [5:0] last_addr = '0;
   logic [31:0] last_wdata = '0;
   always #5 clk = ~clk;
   jtag_dmi_target #(.ACCESS_TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .dtm_req_valid_i(dtm_req_valid_i), .dtm_req_data_i(dtm_req_data_i),
      .dm_ack_o(dm_ack_o), .dm_resp_o(dm_resp_o), .dm_resp_data_o(dm_resp_data_o),
      .dtm_ack_i(dtm_ack_i), .reg_req_o(reg_req_o), .reg_we_o(reg_we_o),
      .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
      .reg_ready_i(reg_ready_i), .reg_rdata_i(reg_rdata_i)
   );
   // Register-port responder: ready in the ready_lat-th cycle of reg_req_o (0 = never).
   always @(posedge clk) begin
      #2;
      if (reg_req_o) begin
         req_cycles++;
         last_we    = reg_we_o;
         last_addr  = reg_addr_o;
         last_wdata = reg_wdata_o;
         reg_ready_i = ready_lat != 0 && req_cycles == ready_lat;
      end else reg_ready_i = 0;
      if (dm_resp_o && !prev_resp) resp_count++;
      prev_resp = dm_resp_o;
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic xfer(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op,
                       input int lat, input logic [31:0] rdata, input bit hold,
                       input logic [39:0] exp_resp, input int exp_rlat, input int exp_cyc,
                       input string tag);
      int n;
      req_cycles = 0; resp_count = 0; ready_lat = lat; reg_rdata_i = rdata;
      dtm_req_data_i = {a, d, op};
      dtm_req_valid_i = 1;
      n = 0;
      while (!dm_ack_o && n < 20) begin @(posedge clk); #1; n++; end
      chk({tag, "_ack_lat"}, n, 3);
      if (!hold) dtm_req_valid_i = 0;
      n = 0;
      while (!dm_resp_o && n < 40) begin @(posedge clk); #1; n++; end
      chk({tag, "_resp_lat"}, n, exp_rlat);
      chk({tag, "_resp"}, dm_resp_data_o, exp_resp);
      dtm_ack_i = 1;
      n = 0;
      while (dm_resp_o && n < 20) begin @(posedge clk); #1; n++; end
      chk({tag, "_resp_drop"}, dm_resp_o, 0);
      dtm_ack_i = 0;
      repeat (8) @(posedge clk);
      #1;
      chk({tag, "_reg_cycles"}, req_cycles, exp_cyc);
      chk({tag, "_nresp"}, resp_count, 1);
      if (hold) begin
         chk({tag, "_ack_held"}, dm_ack_o, 1);
         dtm_req_valid_i = 0;
         n = 0;
         while (dm_ack_o && n < 20) begin @(posedge clk); #1; n++; end
         chk({tag, "_ack_fall"}, n, 3);
         repeat (6) @(posedge clk);
         #1;
         chk({tag, "_nresp_after"}, resp_count, 1);
         chk({tag, "_reg_cycles_after"}, req_cycles, exp_cyc);
      end
      chk({tag, "_ack_idle"}, dm_ack_o, 0);
   endtask
   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", dm_ack_o, 0);
      chk("rst_resp", dm_resp_o, 0);
      chk("rst_resp_data", dm_resp_data_o, 0);
      chk("rst_reg_req", reg_req_o, 0);
      chk("rst_reg_we", reg_we_o, 0);
      chk("rst_reg_addr", reg_addr_o, 0);
      chk("rst_reg_wdata", reg_wdata_o, 0);
      rst_n = 1;
      repeat (2) @(posedge clk);
      #1;
      xfer(6'h11, 32'h0, 2'b01, 3, 32'hDEADBEEF, 0, {6'h11, 32'hDEADBEEF, 2'b00}, 4, 3, "read");
      chk("read_we", last_we, 0);
      chk("read_addr", last_addr, 6'h11);
      xfer(6'h04, 32'h12345678, 2'b10, 1, 32'hFFFFFFFF, 0, {6'h04, 32'h0, 2'b00}, 2, 1, "write");
      chk("write_we", last_we, 1);
      chk("write_addr", last_addr, 6'h04);
      chk("write_wdata", last_wdata, 32'h12345678);
      xfer(6'h07, 32'hAAAA5555, 2'b00, 1, 32'h1, 0, {6'h07, 32'h0, 2'b00}, 0, 0, "nop");
      xfer(6'h3F, 32'h00000001, 2'b11, 1, 32'h1, 0, {6'h3F, 32'h0, 2'b10}, 0, 0, "rsvd");
      xfer(6'h15, 32'h0, 2'b01, 0, 32'h5A5A5A5A, 0, {6'h15, 32'h0, 2'b10}, 9, 8, "timeout");
      xfer(6'h22, 32'h0, 2'b01, 8, 32'h0BADF00D, 0, {6'h22, 32'h0BADF00D, 2'b00}, 9, 8, "tmo_edge");
      xfer(6'h09, 32'h0, 2'b01, 2, 32'h600DCAFE, 1, {6'h09, 32'h600DCAFE, 2'b00}, 3, 2, "hold");
      ready_lat = 1; reg_rdata_i = 32'h11112222;
      dtm_req_data_i = {6'h30, 32'h0, 2'b01};
      dtm_req_valid_i = 1;
      n = 0;
      while (!dm_resp_o && n < 20) begin @(posedge clk); #1; n++; end
      chk("arst_pre_resp", dm_resp_o, 1);
      rst_n = 0;
      #1;
      chk("arst_ack", dm_ack_o, 0);
      chk("arst_resp", dm_resp_o, 0);
      chk("arst_reg_req", reg_req_o, 0);
      chk("arst_resp_data", dm_resp_data_o, 0);
      dtm_req_valid_i = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      repeat (2) @(posedge clk);
      #1;
      xfer(6'h2A, 32'h0, 2'b01, 2, 32'hCAFEF00D, 0, {6'h2A, 32'hCAFEF00D, 2'b00}, 3, 2, "post_rst");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
